multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 15: max consecutive mem_ready-low cycles in FETCH/MEM before fault; 0 disables the timeout.
REQ-002 Parameter CNT_W, default $clog2(TIMEOUT+1) (minimum 1): wait-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 Opcode  in  7  instruction opcode from instruction register; stable from DECODE until the next FETCH completes.
REQ-006 mem_ready  in  1  memory completion, sampled while MemReq=1.
REQ-007 BrTaken  in  1  branch condition from ALU, valid in EXEC.
REQ-008 PCWrite  out  1  load PC.
REQ-009 PCSel  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
REQ-010 IRWrite  out  1  load instruction register.
REQ-011 MemReq  out  1  memory access request.
REQ-012 MemWE  out  1  memory write enable.
REQ-013 IorD  out  1  memory address source: 0 PC, 1 ALU result.
REQ-014 ALUSrc  out  1  0 register operand, 1 immediate.
REQ-015 ALUOp  out  2  00 add (LW/SW/JAL), 01 branch compare, 10 R-type, 11 I-type.
REQ-016 WBSel  out  2  write-back source: 00 ALU, 01 memory, 10 PC+4.
REQ-017 RegWrite  out  1  register file write.
REQ-018 Fault  out  1  sticky fault indication.
REQ-019 State  out  3  current state encoding, for debug.

Function
REQ-020 The block SHALL implement a registered Moore/Mealy FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP.
REQ-021 The block SHALL decode R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011, JAL=1101111.
REQ-022 FETCH: MemReq=1, IorD=0; on mem_ready=1 assert IRWrite=1, PCWrite=1, PCSel=00 in that cycle and go to DECODE; otherwise stay.
REQ-023 DECODE: no control asserted; next state EXEC for a legal opcode.
REQ-024 EXEC R/I: ALUSrc=0/1 respectively, ALUOp=10/11, next state WB.
REQ-025 EXEC LW/SW: ALUSrc=1, ALUOp=00, next state MEM.
REQ-026 EXEC BR: ALUOp=01; PCWrite=BrTaken, PCSel=01; next state FETCH.
REQ-027 EXEC JAL: PCWrite=1, PCSel=10; next state WB.
REQ-028 MEM: MemReq=1, IorD=1, MemWE=1 only for SW; on mem_ready=1 go to WB (LW) or FETCH (SW); otherwise stay.
REQ-029 WB: RegWrite=1, WBSel=01 for LW, 10 for JAL, 00 otherwise; next state FETCH.
REQ-030 Zero-wait latency SHALL be R/I 4, LW 5, SW 4, BR 3, JAL 4 cycles.
REQ-031 Wait counter SHALL clear on every state change and increment each FETCH/MEM cycle with mem_ready=0, saturating at TIMEOUT.
REQ-032 With TIMEOUT>0, a FETCH/MEM cycle with mem_ready=0 and counter equal to TIMEOUT-1 SHALL move to TRAP next cycle; mem_ready=1 in that same cycle SHALL complete normally instead.
REQ-033 TRAP: all outputs 0 except Fault=1; the state SHALL be held until reset.
REQ-034 Unlisted outputs in each state SHALL be 0.

Reset
REQ-035 Reset asserted at a rising edge SHALL set state FETCH, counter 0, Fault 0, from any state including mid-MEM and TRAP.
REQ-036 While reset is high, all outputs SHALL be forced to 0 combinationally; State reads 0.

Configuration
REQ-037 With ILLEGAL_TRAP_EN defined, an undecoded opcode in DECODE SHALL go to TRAP with Fault=1 the next cycle.
REQ-038 Without ILLEGAL_TRAP_EN, an undecoded opcode SHALL be a NOP: DECODE goes to FETCH, no write asserted.

Verification
REQ-039 R-type 0110011, mem_ready always 1 -> states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=10 in EXEC.
REQ-040 LW, mem_ready low 3 cycles in MEM -> MemReq=1, IorD=1 for 4 cycles, then WB with WBSel=01, RegWrite=1.
REQ-041 BR with BrTaken=1 -> PCWrite=1, PCSel=01 in EXEC, then FETCH; BrTaken=0 -> PCWrite=0.
REQ-042 TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP after 15 cycles, Fault=1 sticky; reset -> FETCH, Fault=0.
REQ-043 Opcode 1111111: with ILLEGAL_TRAP_EN -> TRAP after DECODE; without -> back to FETCH, no RegWrite/MemWE.
REQ-044 Reset asserted during MEM of SW -> MemWE=0 immediately, State=0 after the edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory wait timeout.
// Optional feature macro: ILLEGAL_TRAP_EN (undecoded opcode traps instead of acting as a NOP).
module multicycle_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [6:0] i_opcode,
  input  logic       i_mem_ready,
  input  logic       i_br_taken,
  output logic       o_pc_write,
  output logic [1:0] o_pc_sel,
  output logic       o_ir_write,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_iord,
  output logic       o_alu_src,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_wb_sel,
  output logic       o_reg_write,
  output logic       o_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req;
  logic             r_mem_we;
  logic             r_iord;
  logic             r_alu_src;
  logic [1:0]       r_alu_op;
  logic [1:0]       r_pc_sel;
  logic [1:0]       r_wb_sel;
  logic             r_reg_write;
  logic             r_fault;

  state_t w_next;
  logic   w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_legal;
  logic   w_waiting;
  logic   w_timeout;
  logic   w_fetch_done;

  assign w_is_r   = (i_opcode == OP_R);
  assign w_is_i   = (i_opcode == OP_I);
  assign w_is_lw  = (i_opcode == OP_LW);
  assign w_is_sw  = (i_opcode == OP_SW);
  assign w_is_br  = (i_opcode == OP_BR);
  assign w_is_jal = (i_opcode == OP_JAL);
  assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br | w_is_jal;

  assign w_waiting    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
  assign w_fetch_done = (r_state == S_FETCH) && i_mem_ready;

  // The trap fires on the cycle the counter would reach TIMEOUT, so a stall of exactly TIMEOUT cycles faults.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout = w_waiting && (r_cnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        if (w_legal) w_next = S_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (w_is_lw || w_is_sw)                 w_next = S_MEM;
        else if (w_is_r || w_is_i || w_is_jal) w_next = S_WB;
        else                                    w_next = S_FETCH;
      end
      S_MEM: begin
        if (i_mem_ready)    w_next = w_is_lw ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // Moore outputs are registered from the next state; opcode is stable across EXEC/MEM/WB.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_FETCH;
      r_cnt       <= '0;
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_iord      <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= 2'b00;
      r_pc_sel    <= 2'b00;
      r_wb_sel    <= 2'b00;
      r_reg_write <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_waiting && (r_cnt != CNT_SAT))
        r_cnt <= r_cnt + 1'b1;

      r_mem_req   <= (w_next == S_FETCH) || (w_next == S_MEM);
      r_iord      <= (w_next == S_MEM);
      r_mem_we    <= (w_next == S_MEM) && w_is_sw;
      r_alu_src   <= (w_next == S_EXEC) && (w_is_i || w_is_lw || w_is_sw);
      r_reg_write <= (w_next == S_WB);
      r_fault     <= (w_next == S_TRAP);

      r_alu_op <= 2'b00;
      r_pc_sel <= 2'b00;
      if (w_next == S_EXEC) begin
        if (w_is_r)       r_alu_op <= 2'b10;
        else if (w_is_i)  r_alu_op <= 2'b11;
        else if (w_is_br) r_alu_op <= 2'b01;
        if (w_is_br)       r_pc_sel <= 2'b01;
        else if (w_is_jal) r_pc_sel <= 2'b10;
      end

      r_wb_sel <= 2'b00;
      if (w_next == S_WB) begin
        if (w_is_lw)       r_wb_sel <= 2'b01;
        else if (w_is_jal) r_wb_sel <= 2'b10;
      end
    end
  end

  // Outputs that depend on same-cycle inputs, plus combinational forcing to zero during reset.
  assign o_ir_write  = !i_reset && w_fetch_done;
  assign o_pc_write  = !i_reset && (w_fetch_done ||
                                    ((r_state == S_EXEC) && w_is_br && i_br_taken) ||
                                    ((r_state == S_EXEC) && w_is_jal));
  assign o_pc_sel    = i_reset ? 2'b00 : r_pc_sel;
  assign o_mem_req   = !i_reset && r_mem_req;
  assign o_mem_we    = !i_reset && r_mem_we;
  assign o_iord      = !i_reset && r_iord;
  assign o_alu_src   = !i_reset && r_alu_src;
  assign o_alu_op    = i_reset ? 2'b00 : r_alu_op;
  assign o_wb_sel    = i_reset ? 2'b00 : r_wb_sel;
  assign o_reg_write = !i_reset && r_reg_write;
  assign o_fault     = !i_reset && r_fault;
  assign o_state     = i_reset ? 3'd0 : r_state;

endmodule
